// File: rtl/config_sequencer_if.sv
// Host command channel plus the fabric-wide config bus driven by config_sequencer.
interface config_sequencer_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_data;
   logic        clear_start;
   logic        busy;
   logic        clear_done;
   logic [31:0] config_addr;
   logic [31:0] config_data;

   modport master (
      output cmd_valid, cmd_addr, cmd_data, clear_start,
      input  cmd_ready, busy, clear_done, config_addr, config_data
   );

   modport slave (
      input  cmd_valid, cmd_addr, cmd_data, clear_start,
      output cmd_ready, busy, clear_done, config_addr, config_data
   );
endinterface

// File: rtl/config_sequencer.sv
// Sole config bus master: queues host writes in a FIFO and replays each for HOLD_CYCLES plus one idle gap.
// A clear sweep writes zero to every module FIRST_MOD..LAST_MOD of every tile, then pulses clear_done.
module config_sequencer #(
   parameter int          DEPTH       = 4,
   parameter int          HOLD_CYCLES = 1,
   parameter int          NUM_TILES   = 16,
   parameter int          FIRST_MOD   = 4,
   parameter int          LAST_MOD    = 7,
   parameter logic [31:0] IDLE_ADDR   = 32'h0
) (
   input logic               clk,
   input logic               reset,
   config_sequencer_if.slave cfg
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int TW = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_GAP,
      S_CLR_WRITE,
      S_CLR_GAP
   } state_t;

   state_t        r_state;
   logic [63:0]   r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          r_rdy_en;
   logic [HW-1:0] r_hold;
   logic [TW-1:0] r_tile;
   logic [15:0]   r_mod;
   logic [31:0]   r_addr;
   logic [31:0]   r_data;
   logic          r_done;

   logic          w_full;
   logic          w_empty;
   logic          w_push;
   logic          w_pop;
   logic          w_hold_end;
   logic          w_mod_last;
   logic          w_tile_last;
   logic [63:0]   w_head;
   logic [15:0]   w_next_mod;
   logic [TW-1:0] w_next_tile;

   assign w_full      = (r_count == CW'(DEPTH));
   assign w_empty     = (r_count == '0);
   assign w_push      = cfg.cmd_valid && cfg.cmd_ready;
   // Clear has priority in IDLE, so the FIFO is not popped on a clear_start cycle.
   assign w_pop       = !w_empty && (((r_state == S_IDLE) && !cfg.clear_start) || (r_state == S_GAP));
   assign w_head      = r_mem[r_rd_ptr];
   assign w_hold_end  = (r_hold == HW'(HOLD_CYCLES - 1));
   assign w_mod_last  = (r_mod == 16'(LAST_MOD));
   assign w_tile_last = (r_tile == TW'(NUM_TILES - 1));

   always_comb begin
      w_next_mod  = r_mod + 16'd1;
      w_next_tile = r_tile;
      if (w_mod_last) begin
         w_next_mod  = 16'(FIRST_MOD);
         w_next_tile = r_tile + TW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {cfg.cmd_addr, cfg.cmd_data};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CW'(1);
         end else if (w_pop && !w_push) begin
            r_count <= r_count - CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= S_IDLE;
         r_rdy_en <= 1'b0;
         r_hold   <= '0;
         r_tile   <= '0;
         r_mod    <= 16'(FIRST_MOD);
         r_addr   <= IDLE_ADDR;
         r_data   <= '0;
         r_done   <= 1'b0;
      end else begin
         r_rdy_en <= 1'b1;
         r_done   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (cfg.clear_start) begin
                  r_state <= S_CLR_WRITE;
                  r_hold  <= '0;
                  r_tile  <= '0;
                  r_mod   <= 16'(FIRST_MOD);
                  r_addr  <= {16'(FIRST_MOD), 16'h0000};
                  r_data  <= '0;
               end else if (w_pop) begin
                  r_state <= S_WRITE;
                  r_hold  <= '0;
                  r_addr  <= w_head[63:32];
                  r_data  <= w_head[31:0];
               end
            end
            S_WRITE, S_CLR_WRITE: begin
               if (w_hold_end) begin
                  r_state <= (r_state == S_WRITE) ? S_GAP : S_CLR_GAP;
                  r_addr  <= IDLE_ADDR;
                  r_data  <= '0;
               end else begin
                  r_hold <= r_hold + HW'(1);
               end
            end
            S_GAP: begin
               if (w_pop) begin
                  r_state <= S_WRITE;
                  r_hold  <= '0;
                  r_addr  <= w_head[63:32];
                  r_data  <= w_head[31:0];
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_CLR_GAP: begin
               if (w_mod_last && w_tile_last) begin
                  r_state <= S_IDLE;
                  r_done  <= 1'b1;
               end else begin
                  r_state <= S_CLR_WRITE;
                  r_hold  <= '0;
                  r_mod   <= w_next_mod;
                  r_tile  <= w_next_tile;
                  r_addr  <= {w_next_mod, 16'(w_next_tile)};
                  r_data  <= '0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_addr  <= IDLE_ADDR;
               r_data  <= '0;
            end
         endcase
      end
   end

   assign cfg.cmd_ready   = r_rdy_en && !w_full;
   assign cfg.busy        = (r_state != S_IDLE) || !w_empty;
   assign cfg.clear_done  = r_done;
   assign cfg.config_addr = r_addr;
   assign cfg.config_data = r_data;
endmodule

// File: tb/tb_config_sequencer.sv
// Drives two sequencers (HOLD_CYCLES 1 and 3) with shared stimulus; each is checked every cycle
// against a schedule model: a queue of expected bus cycles built from whole writes and sweeps.
module tb_config_sequencer;
   localparam int NI        = 2;
   localparam int DEPTH     = 4;
   localparam int NUM_TILES = 2;
   localparam int FIRST_MOD = 4;
   localparam int LAST_MOD  = 7;

   typedef struct packed {
      logic        done;
      logic [31:0] addr;
      logic [31:0] data;
   } ent_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        tb_valid = 1'b0;
   logic        tb_clear = 1'b0;
   logic [31:0] tb_addr  = '0;
   logic [31:0] tb_data  = '0;

   always #5 clk = ~clk;

   config_sequencer_if bus0 ();
   config_sequencer_if bus1 ();

   assign bus0.cmd_valid   = tb_valid;
   assign bus0.cmd_addr    = tb_addr;
   assign bus0.cmd_data    = tb_data;
   assign bus0.clear_start = tb_clear;
   assign bus1.cmd_valid   = tb_valid;
   assign bus1.cmd_addr    = tb_addr;
   assign bus1.cmd_data    = tb_data;
   assign bus1.clear_start = tb_clear;

   config_sequencer #(
      .DEPTH(DEPTH), .HOLD_CYCLES(1), .NUM_TILES(NUM_TILES),
      .FIRST_MOD(FIRST_MOD), .LAST_MOD(LAST_MOD), .IDLE_ADDR(32'h0)
   ) u_dut_h1 (
      .clk(clk), .reset(reset), .cfg(bus0)
   );

   config_sequencer #(
      .DEPTH(DEPTH), .HOLD_CYCLES(3), .NUM_TILES(NUM_TILES),
      .FIRST_MOD(FIRST_MOD), .LAST_MOD(LAST_MOD), .IDLE_ADDR(32'h0)
   ) u_dut_h3 (
      .clk(clk), .reset(reset), .cfg(bus1)
   );

   logic [NI-1:0] obs_rdy, obs_busy, obs_done;
   logic [31:0]   obs_addr [NI];
   logic [31:0]   obs_data [NI];

   assign obs_rdy[0]  = bus0.cmd_ready;
   assign obs_busy[0] = bus0.busy;
   assign obs_done[0] = bus0.clear_done;
   assign obs_addr[0] = bus0.config_addr;
   assign obs_data[0] = bus0.config_data;
   assign obs_rdy[1]  = bus1.cmd_ready;
   assign obs_busy[1] = bus1.busy;
   assign obs_done[1] = bus1.clear_done;
   assign obs_addr[1] = bus1.config_addr;
   assign obs_data[1] = bus1.config_data;

   ent_t        m_sched [NI][$];
   logic [63:0] m_fifo  [NI][$];
   bit          m_en    [NI];
   int          n_done_exp [NI];
   int          n_done_obs [NI];

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int hold_of(input int i);
      return (i == 0) ? 1 : 3;
   endfunction

   function automatic ent_t mk(input logic done, input logic [31:0] a, input logic [31:0] d);
      ent_t e;
      e.done = done;
      e.addr = a;
      e.data = d;
      return e;
   endfunction

   task automatic sched_write(input int i, input logic [31:0] a, input logic [31:0] d);
      for (int k = 0; k < hold_of(i); k++) m_sched[i].push_back(mk(1'b0, a, d));
      m_sched[i].push_back(mk(1'b0, 32'h0, 32'h0));
   endtask

   task automatic sched_sweep(input int i);
      for (int t = 0; t < NUM_TILES; t++)
         for (int m = FIRST_MOD; m <= LAST_MOD; m++)
            sched_write(i, {16'(m), 16'(t)}, 32'h0);
      m_sched[i].push_back(mk(1'b1, 32'h0, 32'h0));
   endtask

   // Sequencer idles when nothing is scheduled or only the clear_done cycle remains.
   task automatic model_edge();
      bit   idle_state;
      bit   push;
      ent_t dummy;
      for (int i = 0; i < NI; i++) begin
         push       = tb_valid && m_en[i] && (m_fifo[i].size() < DEPTH);
         idle_state = (m_sched[i].size() == 0) || m_sched[i][0].done;
         if (m_sched[i].size() != 0) dummy = m_sched[i].pop_front();
         if (idle_state && tb_clear) sched_sweep(i);
         else if (m_sched[i].size() == 0 && m_fifo[i].size() != 0) begin
            logic [63:0] c;
            c = m_fifo[i].pop_front();
            sched_write(i, c[63:32], c[31:0]);
         end
         if (push) m_fifo[i].push_back({tb_addr, tb_data});
         m_en[i] = 1'b1;
      end
   endtask

   task automatic compare();
      ent_t h;
      logic exp_busy;
      logic exp_rdy;
      string p;
      for (int i = 0; i < NI; i++) begin
         p = $sformatf("h%0d", hold_of(i));
         h = (m_sched[i].size() != 0) ? m_sched[i][0] : mk(1'b0, 32'h0, 32'h0);
         exp_busy = ((m_sched[i].size() != 0) && !h.done) || (m_fifo[i].size() != 0);
         exp_rdy  = m_en[i] && (m_fifo[i].size() < DEPTH);
         if (h.done) n_done_exp[i]++;
         if (obs_done[i]) n_done_obs[i]++;
         check({p, "_addr"}, 64'(obs_addr[i]), 64'(h.addr));
         check({p, "_data"}, 64'(obs_data[i]), 64'(h.data));
         check({p, "_busy"}, 64'(obs_busy[i]), 64'(exp_busy));
         check({p, "_done"}, 64'(obs_done[i]), 64'(h.done));
         check({p, "_ready"}, 64'(obs_rdy[i]), 64'(exp_rdy));
      end
   endtask

   task automatic step();
      @(posedge clk);
      if (reset) model_edge();
      @(negedge clk);
      compare();
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic send(input logic [31:0] a, input logic [31:0] d);
      tb_valid = 1'b1;
      tb_addr  = a;
      tb_data  = d;
      step();
      tb_valid = 1'b0;
   endtask

   task automatic pulse_clear();
      tb_clear = 1'b1;
      step();
      tb_clear = 1'b0;
   endtask

   task automatic reset_checks(input string tag);
      for (int i = 0; i < NI; i++) begin
         check({tag, "_addr"}, 64'(obs_addr[i]), 64'h0);
         check({tag, "_data"}, 64'(obs_data[i]), 64'h0);
         check({tag, "_busy"}, 64'(obs_busy[i]), 64'h0);
         check({tag, "_done"}, 64'(obs_done[i]), 64'h0);
         check({tag, "_ready"}, 64'(obs_rdy[i]), 64'h0);
      end
   endtask

   task automatic reset_now(input string tag);
      #2 reset = 1'b0;
      #1 reset_checks(tag);
      tb_valid = 1'b0;
      tb_clear = 1'b0;
      for (int i = 0; i < NI; i++) begin
         m_sched[i].delete();
         m_fifo[i].delete();
         m_en[i] = 1'b0;
      end
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   function automatic bit model_idle();
      for (int i = 0; i < NI; i++)
         if (m_sched[i].size() != 0 || m_fifo[i].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic drain(input string tag);
      for (int k = 0; k < 400 && !model_idle(); k++) step();
      step();
      for (int i = 0; i < NI; i++) check({tag, "_busy"}, 64'(obs_busy[i]), 64'h0);
   endtask

   initial begin
      for (int i = 0; i < NI; i++) begin
         m_en[i]       = 1'b0;
         n_done_exp[i] = 0;
         n_done_obs[i] = 0;
      end
      reset = 1'b1;
      #1 reset = 1'b0;
      #1 reset_checks("rst0");
      repeat (2) @(negedge clk);
      reset = 1'b1;
      idle(2);

      send(32'h0005_0003, 32'h0000_002A);
      idle(6);

      for (int k = 0; k < 5; k++) begin
         tb_valid = 1'b1;
         tb_addr  = {16'(k + 1), 16'(k)};
         tb_data  = 32'hA0 + 32'(k);
         step();
      end
      tb_valid = 1'b0;
      idle(14);

      pulse_clear();
      idle(40);

      // Clear and a push on the same edge, a second push behind it: both wait out the sweep.
      tb_clear = 1'b1;
      tb_valid = 1'b1;
      tb_addr  = 32'h0006_0001;
      tb_data  = 32'h1111_1111;
      step();
      tb_clear = 1'b0;
      tb_addr  = 32'h0007_0000;
      tb_data  = 32'h2222_2222;
      step();
      tb_valid = 1'b0;
      idle(45);

      send(32'h0004_0001, 32'hDEAD_BEEF);
      step();
      pulse_clear();
      idle(10);

      pulse_clear();
      for (int k = 0; k < 12; k++) begin
         tb_valid = 1'b1;
         tb_addr  = $urandom;
         tb_data  = $urandom;
         step();
      end
      tb_valid = 1'b0;
      drain("drain1");

      for (int k = 0; k < 800; k++) begin
         tb_valid = ($urandom_range(0, 1) == 1);
         tb_clear = ($urandom_range(0, 39) == 0);
         tb_addr  = {16'($urandom_range(0, 9)), 16'($urandom_range(0, 15))};
         tb_data  = $urandom;
         step();
      end
      tb_valid = 1'b0;
      tb_clear = 1'b0;
      drain("drain2");

      pulse_clear();
      send(32'h0005_0001, 32'h5555_5555);
      idle(8);
      reset_now("rst_mid");
      idle(3);
      send(32'h0004_0000, 32'h7777_0000);
      drain("drain3");

      for (int i = 0; i < NI; i++)
         check($sformatf("h%0d_done_count", hold_of(i)), 64'(n_done_obs[i]), 64'(n_done_exp[i]));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
